// File: rtl/dmem_ctrl.sv
// Data-memory controller: word-organised RAM with byte-lane stores, one-cycle
// registered loads (stalling the core for the issue cycle) and a sticky misalignment flag.
module dmem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    input  logic [2:0]  s_type,
    input  logic [2:0]  l_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        misalign_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       ram_rd_q;

    logic [0:0]        state_q, state_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        off_q, off_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              unused_addr_bits;

    logic              st_aligned;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic              st_we;

    logic              ld_aligned;
    logic              ld_req;
    logic              rd_issue;

    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       fmt_data;

    // Upper address bits are ignored, so accesses wrap modulo the RAM size.
    assign word_idx         = mem_addr[ADDR_W+1:2];
    assign byte_off         = mem_addr[1:0];
    assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

    always_comb begin
        st_aligned = 1'b1;
        st_be      = 4'b0000;
        st_data    = mem_wdata;
        case (s_type)
            3'b000: begin
                st_be   = 4'b0001 << byte_off;
                st_data = {4{mem_wdata[7:0]}};
            end
            3'b001: begin
                st_aligned = ~byte_off[0];
                st_be      = byte_off[1] ? 4'b1100 : 4'b0011;
                st_data    = {2{mem_wdata[15:0]}};
            end
            3'b010: begin
                st_aligned = (byte_off == 2'b00);
                st_be      = 4'b1111;
            end
            default: st_be = 4'b0000;
        endcase
    end

    assign st_we = mem_write_en & st_aligned;

    always_comb begin
        case (l_type)
            3'b001, 3'b101: ld_aligned = ~byte_off[0];
            3'b010:         ld_aligned = (byte_off == 2'b00);
            default:        ld_aligned = 1'b1;
        endcase
    end

    // A store in the same cycle wins; the read is dropped without a stall.
    assign ld_req   = mem_read_en & ~mem_write_en & (state_q == IDLE);
    assign rd_issue = ld_req & ld_aligned;
    assign stall    = rd_issue & reset;

    always_comb begin
        state_d    = rd_issue ? RESP : IDLE;
        ltype_d    = rd_issue ? l_type : ltype_q;
        off_d      = rd_issue ? byte_off : off_q;
        misalign_d = misalign_q | (mem_write_en & ~st_aligned) | (ld_req & ~ld_aligned);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ltype_q    <= 3'b000;
            off_q      <= 2'b00;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ltype_q    <= ltype_d;
            off_q      <= off_d;
            misalign_q <= misalign_d;
        end
    end

    // RAM carries no reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (st_we && st_be[i]) begin
                ram[word_idx][i*8 +: 8] <= st_data[i*8 +: 8];
            end
        end
        if (rd_issue) begin
            ram_rd_q <= ram[word_idx];
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   sel_byte = ram_rd_q[7:0];
            2'b01:   sel_byte = ram_rd_q[15:8];
            2'b10:   sel_byte = ram_rd_q[23:16];
            default: sel_byte = ram_rd_q[31:24];
        endcase
        sel_half = off_q[1] ? ram_rd_q[31:16] : ram_rd_q[15:0];
        case (ltype_q)
            3'b000:  fmt_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  fmt_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  fmt_data = ram_rd_q;
            3'b100:  fmt_data = {24'h000000, sel_byte};
            3'b101:  fmt_data = {16'h0000, sel_half};
            default: fmt_data = 32'h0000_0000;
        endcase
    end

    assign mem_rdata    = (state_q == RESP) ? fmt_data : 32'h0000_0000;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-addressed reference memory.
module tb_dmem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write_en = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [2:0]  s_type = 3'b000;
    logic [2:0]  l_type = 3'b000;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mb [NBYTES];
    bit         m_mis = 1'b0;

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .s_type(s_type), .l_type(l_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int st_size(input logic [2:0] t);
        case (t)
            3'b000: return 1;
            3'b001: return 2;
            3'b010: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int ld_size(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ld_ok(input logic [31:0] a, input logic [2:0] t);
        int sz = ld_size(t);
        return (sz == 0) || ((int'(a[1:0]) % sz) == 0);
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        int sz = st_size(t);
        int b  = int'(a % NBYTES);
        if (sz == 0) return;
        if ((b % sz) != 0) begin
            m_mis = 1'b1;
            return;
        end
        for (int i = 0; i < sz; i++) mb[b + i] = 8'(d >> (8 * i));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t);
        int sz = ld_size(t);
        int b  = int'(a % NBYTES);
        logic [31:0] v = 32'h0;
        if (sz == 0) return 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[b + i]) << (8 * i));
        if (t[2] == 1'b0 && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (t[2] == 1'b0 && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                            input logic also_read, output logic stall_seen);
        @(negedge clk);
        mem_write_en = 1'b1; mem_read_en = also_read;
        s_type = t; l_type = 3'b010; mem_addr = a; mem_wdata = d;
        #1 stall_seen = stall;
        @(posedge clk);
        #1;
        mem_write_en = 1'b0; mem_read_en = 1'b0;
        m_store(a, d, t);
    endtask

    // Issue cycle observed at issue_*, following cycle at resp_*; inputs are scrambled in between.
    task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                           output logic issue_stall, output logic [31:0] issue_rd,
                           output logic resp_stall, output logic [31:0] resp_rd);
        @(negedge clk);
        mem_write_en = 1'b0; mem_read_en = 1'b1; l_type = t; mem_addr = a;
        #1;
        issue_stall = stall;
        issue_rd    = mem_rdata;
        @(posedge clk);
        #1;
        mem_read_en = 1'b0; mem_addr = $urandom; l_type = 3'($urandom);
        @(negedge clk);
        resp_stall = stall;
        resp_rd    = mem_rdata;
        if (!ld_ok(a, t)) m_mis = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        mem_read_en = 1'b1; l_type = 3'b010; mem_addr = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_held: got %b expected 0", stall);
        end
        mem_read_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        checks++;
        if (mem_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00000000", mem_rdata);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err);
        end
        m_mis = 1'b0;
    endtask

    task automatic test_sw_lw();
        logic s, is, rs;
        logic [31:0] ir, rr;
        do_store(32'h10, 32'h8000_00F1, 3'b010, 1'b0, s);
        checks++;
        if (s !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b expected 0", s); end
        do_load(32'h10, 3'b010, is, ir, rs, rr);
        checks++;
        if (is !== 1'b1) begin errors++; $display("FAIL lw_issue_stall: got %b expected 1", is); end
        checks++;
        if (rr !== 32'h8000_00F1) begin errors++; $display("FAIL lw_data: got %h expected 800000f1", rr); end
        checks++;
        if (rs !== 1'b0) begin errors++; $display("FAIL lw_resp_stall: got %b expected 0", rs); end
        $display("sw/lw 0x10: issue_stall=%b data=%h", is, rr);
    endtask

    task automatic test_byte();
        logic s, is, rs;
        logic [31:0] ir, rr;
        logic [31:0] exp_v [3] = '{32'h0000_AB00, 32'hFFFF_FFAB, 32'h0000_00AB};
        logic [2:0]  lts   [3] = '{3'b010, 3'b000, 3'b100};
        logic [31:0] ads   [3] = '{32'h20, 32'h21, 32'h21};
        do_store(32'h20, 32'h0, 3'b010, 1'b0, s);
        do_store(32'h21, 32'h1234_56AB, 3'b000, 1'b0, s);
        for (int i = 0; i < 3; i++) begin
            do_load(ads[i], lts[i], is, ir, rs, rr);
            checks++;
            if (rr !== exp_v[i]) begin
                errors++; $display("FAIL byte_load%0d: got %h expected %h", i, rr, exp_v[i]);
            end
            $display("byte load addr=%h type=%0d data=%h", ads[i], lts[i], rr);
        end
    endtask

    task automatic test_half();
        logic s, is, rs;
        logic [31:0] ir, rr;
        logic [31:0] exp_v [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_1234};
        logic [2:0]  lts   [3] = '{3'b001, 3'b101, 3'b101};
        logic [31:0] ads   [3] = '{32'h32, 32'h32, 32'h30};
        do_store(32'h30, 32'h0000_1234, 3'b010, 1'b0, s);
        do_store(32'h32, 32'hCAFE_8001, 3'b001, 1'b0, s);
        for (int i = 0; i < 3; i++) begin
            do_load(ads[i], lts[i], is, ir, rs, rr);
            checks++;
            if (rr !== exp_v[i]) begin
                errors++; $display("FAIL half_load%0d: got %h expected %h", i, rr, exp_v[i]);
            end
            $display("half load addr=%h type=%0d data=%h", ads[i], lts[i], rr);
        end
    endtask

    task automatic test_misalign();
        logic s, is, rs;
        logic [31:0] ir, rr;
        do_load(32'h13, 3'b010, is, ir, rs, rr);
        checks++;
        if (is !== 1'b0) begin errors++; $display("FAIL mis_lw_stall: got %b expected 0", is); end
        checks++;
        if (ir !== 32'h0 || rr !== 32'h0) begin
            errors++; $display("FAIL mis_lw_rdata: got %h/%h expected 0/0", ir, rr);
        end
        checks++;
        if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag_set: got %b expected 1", misalign_err); end
        do_store(32'h40, 32'h5566_7788, 3'b010, 1'b0, s);
        do_store(32'h41, 32'hDEAD_BEEF, 3'b001, 1'b0, s);
        do_load(32'h40, 3'b010, is, ir, rs, rr);
        checks++;
        if (rr !== 32'h5566_7788) begin errors++; $display("FAIL mis_sh_nowrite: got %h expected 55667788", rr); end
        checks++;
        if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag_sticky: got %b expected 1", misalign_err); end
        $display("misalign: flag=%b word40=%h", misalign_err, rr);
    endtask

    task automatic test_simul_and_wrap();
        logic s, is, rs;
        logic [31:0] ir, rr;
        do_store(32'h50, 32'hA5A5_0F0F, 3'b010, 1'b1, s);
        checks++;
        if (s !== 1'b0) begin errors++; $display("FAIL simul_stall: got %b expected 0", s); end
        do_load(32'h50, 3'b010, is, ir, rs, rr);
        checks++;
        if (rr !== 32'hA5A5_0F0F) begin errors++; $display("FAIL simul_write: got %h expected a5a50f0f", rr); end
        do_store(32'(DEPTH * 4 + 4), 32'h1234_5678, 3'b010, 1'b0, s);
        do_load(32'h4, 3'b010, is, ir, rs, rr);
        checks++;
        if (rr !== 32'h1234_5678) begin errors++; $display("FAIL wrap: got %h expected 12345678", rr); end
        $display("wrap load 0x4: data=%h", rr);
    endtask

    task automatic test_reset_mid_load();
        logic is, rs;
        logic [31:0] ir, rr;
        @(negedge clk);
        mem_read_en = 1'b1; l_type = 3'b010; mem_addr = 32'h10;
        @(posedge clk);
        #1;
        mem_read_en = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_in_resp: got stall=%b rdata=%h expected 0/00000000", stall, mem_rdata);
        end
        checks++;
        if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_clears_flag: got %b expected 0", misalign_err); end
        m_mis = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_load(32'h10, 3'b010, is, ir, rs, rr);
        checks++;
        if (is !== 1'b1 || rr !== 32'h8000_00F1) begin
            errors++; $display("FAIL post_reset_lw: got stall=%b data=%h expected 1/800000f1", is, rr);
        end
        $display("reset mid-load then lw: data=%h", rr);
    endtask

    task automatic test_random();
        logic s, is, rs;
        logic [31:0] ir, rr, a, d, ev;
        logic [2:0] t;
        logic [2:0] lt_pool [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        for (int w = 0; w < DEPTH; w++) do_store(32'(w * 4), $urandom, 3'b010, 1'b0, s);
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                t = 3'($urandom_range(0, 3));
                do_store(a, d, t, 1'b0, s);
                checks++;
                if (s !== 1'b0) begin errors++; $display("FAIL rnd_store_stall: got %b expected 0", s); end
            end else begin
                t = lt_pool[$urandom_range(0, 5)];
                ev = ld_ok(a, t) ? m_load(a, t) : 32'h0;
                do_load(a, t, is, ir, rs, rr);
                checks++;
                if (is !== 1'(ld_ok(a, t)) || rr !== ev || rs !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_load: addr=%h type=%0d got stall=%b data=%h expected stall=%b data=%h",
                             a, t, is, rr, ld_ok(a, t), ev);
                end
                $display("rnd load addr=%h type=%0d data=%h", a, t, rr);
            end
            checks++;
            if (misalign_err !== m_mis) begin
                errors++; $display("FAIL rnd_flag: got %b expected %b", misalign_err, m_mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_misalign();
        test_simul_and_wrap();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the RV32I core's memory port. Consumes the ALU address, store data and store/load type codes; produces formatted load data.
- Holds a word-organised synchronous RAM with byte-lane writes and a 1-cycle read latency.
- Because reads are registered, the block raises a stall to the core for one cycle on every load. It also flags misaligned accesses.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two)
- ADDR_W, 8, word-index width, equal to log2(DEPTH)

Ports:
- clk  input  1  system clock; rising edge active
- reset  input  1  asynchronous, active-low reset
- mem_write_en  input  1  store request this cycle
- mem_read_en  input  1  load request this cycle
- s_type  input  3  store funct3: 000 SB, 001 SH, 010 SW
- l_type  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_addr  input  32  byte address (ALU result)
- mem_wdata  input  32  store data, right-aligned (rs2)
- mem_rdata  output  32  formatted load data
- stall  output  1  core must hold PC and all architectural state
- misalign_err  output  1  sticky misaligned-access flag

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; stall=0, mem_rdata=0, misalign_err=0.
  - RAM contents are not reset.
- Word index is mem_addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- Alignment:
  - Halfword access is misaligned if addr[0]=1.
  - Word access is misaligned if addr[1:0]!=0.
  - Byte accesses are always aligned.
- Stores (single cycle, never stall):
  - On the clk edge with mem_write_en=1 and the access aligned, write byte lanes.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - SW: all four lanes get wdata.
  - Unaffected lanes keep their contents.
  - Undefined s_type: no write.
- Loads, FSM with two states, IDLE and RESP:
  - IDLE: if mem_read_en=1, mem_write_en=0 and the access is aligned, issue the RAM read, drive stall=1 combinationally and go to RESP. Otherwise stay in IDLE with stall=0.
  - RESP: stall=0. mem_rdata is the RAM output formatted by the l_type and addr[1:0] latched at issue. Always return to IDLE on the next edge.
  - Load latency is 2 cycles. Back-to-back loads give IDLE, RESP, IDLE, RESP.
  - The latched l_type/addr are used in RESP so that the core's inputs changing does not corrupt the result.
- Load formatting:
  - LB / LH: sign-extend the selected byte or halfword.
  - LBU / LHU: zero-extend the selected byte or halfword.
  - LW: full word.
  - Undefined l_type: return 0.
- mem_rdata is 0 in every cycle outside RESP.
- Misaligned load or store:
  - No RAM access and no stall; mem_rdata=0.
  - misalign_err is set on that edge and stays 1 until reset.
- Simultaneous mem_write_en=1 and mem_read_en=1: the store executes, the read is ignored and there is no stall.
- Reset asserted in RESP: returns to IDLE immediately, stall=0, and the pending load data is discarded.
- A store followed by a load to the same word in the next instruction returns the new data (write completes at the edge before the read issues).

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles and release -> stall=0, mem_rdata=0x00000000, misalign_err=0.
- SW 0x8000_00F1 to addr 0x10, then LW addr 0x10 -> stall=1 in cycle 1; mem_rdata=0x800000F1 in cycle 2; stall=0.
- Byte-lane stores and signed/unsigned loads:
  - SB 0xAB to addr 0x21 over prior word 0 -> LW addr 0x20 returns 0x0000AB00.
  - LB addr 0x21 returns 0xFFFFFFAB.
  - LBU addr 0x21 returns 0x000000AB.
- Halfword: SH 0x8001 to addr 0x32 -> LH addr 0x32 returns 0xFFFF8001; LHU returns 0x00008001; lower halfword unchanged.
- Misalignment: LW addr 0x13 -> no stall, mem_rdata=0, misalign_err=1 and stays 1 after later aligned ops. SH addr 0x41 -> word 0x40 unchanged.
- Wrap and reset-mid-load:
  - SW 0x12345678 to addr DEPTH*4+0x4 -> LW addr 0x4 returns 0x12345678.
  - Assert reset during RESP -> stall=0 and mem_rdata=0 immediately.
  - After release, the first LW behaves normally.
